// File: rtl/axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// axi_rd_arbiter
//
// Shares one AXI read slave port between NM masters. A round-robin pick is
// made on the read-address channel and the grant is held until the LAST beat
// of the read-data burst, so exactly one burst is outstanding at a time.
// ID, address, LEN and BURST pass straight through; outside IDLE every data
// path is combinational.
//
// Optional watchdog: define AXI_RD_ARB_TIMEOUT_EN to add a stall counter.
// When TIMEOUT_CYC cycles pass without a handshake in ADDR or DATA, the
// granted master gets a single SLVERR/LAST beat (ERR), then any late slave
// beats are drained (FLUSH) before returning to IDLE.
//
// Ports
//   clk, rstn                       clock, asynchronous active-low reset
//   M_RD_ADDR_ID/ADDR/LEN/BURST     packed per-master AR fields (master i in
//                                   slice i of each vector)
//   M_RD_ADDR_VALID / _READY        per-master AR handshake
//   M_RD_BACK_ID/DATA/DATA_RESP/LAST  R fields broadcast to every master
//   M_RD_DATA_VALID / _READY        per-master R handshake (granted bit only)
//   S_RD_ADDR_*                     muxed AR channel to the slave
//   S_RD_BACK_ID/DATA/RESP/LAST     R channel from the slave
//   S_RD_DATA_VALID / _READY        slave R handshake
//   grant                           current or most recently granted master
//   busy                            high in any state other than IDLE
// ---------------------------------------------------------------------------
module axi_rd_arbiter #(
   parameter int NM          = 2,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic [NM*4-1:0]         M_RD_ADDR_ID,
   input  logic [NM*32-1:0]        M_RD_ADDR,
   input  logic [NM*8-1:0]         M_RD_ADDR_LEN,
   input  logic [NM*2-1:0]         M_RD_ADDR_BURST,
   input  logic [NM-1:0]           M_RD_ADDR_VALID,
   output logic [NM-1:0]           M_RD_ADDR_READY,
   output logic [3:0]              M_RD_BACK_ID,
   output logic [31:0]             M_RD_DATA,
   output logic [1:0]              M_RD_DATA_RESP,
   output logic                    M_RD_DATA_LAST,
   output logic [NM-1:0]           M_RD_DATA_VALID,
   input  logic [NM-1:0]           M_RD_DATA_READY,
   output logic [3:0]              S_RD_ADDR_ID,
   output logic [31:0]             S_RD_ADDR,
   output logic [7:0]              S_RD_ADDR_LEN,
   output logic [1:0]              S_RD_ADDR_BURST,
   output logic                    S_RD_ADDR_VALID,
   input  logic                    S_RD_ADDR_READY,
   input  logic [3:0]              S_RD_BACK_ID,
   input  logic [31:0]             S_RD_DATA,
   input  logic [1:0]              S_RD_DATA_RESP,
   input  logic                    S_RD_DATA_LAST,
   input  logic                    S_RD_DATA_VALID,
   output logic                    S_RD_DATA_READY,
   output logic [$clog2(NM)-1:0]   grant,
   output logic                    busy
);

   localparam int GW = $clog2(NM);
   // Reset to the last master so master 0 wins the first arbitration.
   localparam logic [GW-1:0] GRANT_RST = GW'(NM - 1);
   localparam logic [GW:0]   NM_W      = (GW + 1)'(NM);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_ADDR  = 3'd1;
   localparam logic [2:0] ST_DATA  = 3'd2;
`ifdef AXI_RD_ARB_TIMEOUT_EN
   localparam logic [2:0] ST_ERR   = 3'd3;
   localparam logic [2:0] ST_FLUSH = 3'd4;
   localparam int         CW       = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

   logic [CW-1:0] cnt_q, cnt_d;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

   logic [2:0]    state_q, state_d;
   logic [GW-1:0] grant_q, grant_d;

   // Unpacked views of the packed per-master address fields.
   logic [3:0]  m_id_a    [NM];
   logic [31:0] m_addr_a  [NM];
   logic [7:0]  m_len_a   [NM];
   logic [1:0]  m_burst_a [NM];

   for (genvar i = 0; i < NM; i++) begin : g_unpack
      assign m_id_a[i]    = M_RD_ADDR_ID[4*i +: 4];
      assign m_addr_a[i]  = M_RD_ADDR[32*i +: 32];
      assign m_len_a[i]   = M_RD_ADDR_LEN[8*i +: 8];
      assign m_burst_a[i] = M_RD_ADDR_BURST[2*i +: 2];
   end

   logic addr_hs, data_hs;
   assign addr_hs = (state_q == ST_ADDR) && M_RD_ADDR_VALID[grant_q] && S_RD_ADDR_READY;
   assign data_hs = (state_q == ST_DATA) && S_RD_DATA_VALID && M_RD_DATA_READY[grant_q];

   // Round-robin scan starting just after the previous grant, so the last
   // winner has the lowest priority.
   logic [GW-1:0] rr_pick;
   logic          rr_hit;
   logic [GW:0]   rr_idx;

   always_comb begin
      // NOTE: every variable written here gets a default first so no path
      // through the logic leaves it unassigned and infers a latch.
      rr_pick = grant_q;
      rr_hit  = 1'b0;
      rr_idx  = '0;
      for (int k = 1; k <= NM; k++) begin
         rr_idx = {1'b0, grant_q} + (GW + 1)'(k);
         if (rr_idx >= NM_W) rr_idx = rr_idx - NM_W;
         if (!rr_hit && M_RD_ADDR_VALID[rr_idx[GW-1:0]]) begin
            rr_hit  = 1'b1;
            rr_pick = rr_idx[GW-1:0];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
`ifdef AXI_RD_ARB_TIMEOUT_EN
      cnt_d   = '0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (rr_hit) begin
               grant_d = rr_pick;
               state_d = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (addr_hs) state_d = ST_DATA;
            // Master withdrew VALID before the handshake: abandon quietly.
            else if (!M_RD_ADDR_VALID[grant_q]) state_d = ST_IDLE;
`ifdef AXI_RD_ARB_TIMEOUT_EN
            else if (cnt_q == TO_LAST) state_d = ST_ERR;
            else cnt_d = cnt_q + 1'b1;
`endif
         end
         ST_DATA: begin
            if (data_hs && S_RD_DATA_LAST) state_d = ST_IDLE;
`ifdef AXI_RD_ARB_TIMEOUT_EN
            else if (!data_hs) begin
               if (cnt_q == TO_LAST) state_d = ST_ERR;
               else cnt_d = cnt_q + 1'b1;
            end
`endif
         end
`ifdef AXI_RD_ARB_TIMEOUT_EN
         ST_ERR: begin
            if (M_RD_DATA_READY[grant_q]) state_d = ST_FLUSH;
         end
         ST_FLUSH: begin
            // Idle-cycle count restarts on every discarded beat.
            if (S_RD_DATA_VALID) begin
               if (S_RD_DATA_LAST) state_d = ST_IDLE;
            end
            else if (cnt_q == TO_LAST) state_d = ST_IDLE;
            else cnt_d = cnt_q + 1'b1;
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         grant_q <= GRANT_RST;
`ifdef AXI_RD_ARB_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end
      else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values, independent of statement order.
         state_q <= state_d;
         grant_q <= grant_d;
`ifdef AXI_RD_ARB_TIMEOUT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   always_comb begin
      M_RD_ADDR_READY = '0;
      M_RD_DATA_VALID = '0;
      M_RD_BACK_ID    = '0;
      M_RD_DATA       = '0;
      M_RD_DATA_RESP  = '0;
      M_RD_DATA_LAST  = 1'b0;
      S_RD_ADDR_ID    = '0;
      S_RD_ADDR       = '0;
      S_RD_ADDR_LEN   = '0;
      S_RD_ADDR_BURST = '0;
      S_RD_ADDR_VALID = 1'b0;
      S_RD_DATA_READY = 1'b0;
      case (state_q)
         ST_ADDR: begin
            M_RD_ADDR_READY[grant_q] = S_RD_ADDR_READY;
            if (M_RD_ADDR_VALID[grant_q]) begin
               S_RD_ADDR_VALID = 1'b1;
               S_RD_ADDR_ID    = m_id_a[grant_q];
               S_RD_ADDR       = m_addr_a[grant_q];
               S_RD_ADDR_LEN   = m_len_a[grant_q];
               S_RD_ADDR_BURST = m_burst_a[grant_q];
            end
         end
         ST_DATA: begin
            M_RD_DATA_VALID[grant_q] = S_RD_DATA_VALID;
            S_RD_DATA_READY          = M_RD_DATA_READY[grant_q];
            if (S_RD_DATA_VALID) begin
               M_RD_BACK_ID   = S_RD_BACK_ID;
               M_RD_DATA      = S_RD_DATA;
               M_RD_DATA_RESP = S_RD_DATA_RESP;
               M_RD_DATA_LAST = S_RD_DATA_LAST;
            end
         end
`ifdef AXI_RD_ARB_TIMEOUT_EN
         ST_ERR: begin
            M_RD_DATA_VALID[grant_q] = 1'b1;
            M_RD_BACK_ID             = m_id_a[grant_q];
            M_RD_DATA_RESP           = 2'b10;
            M_RD_DATA_LAST           = 1'b1;
         end
         ST_FLUSH: S_RD_DATA_READY = 1'b1;
`endif
         default: ;
      endcase
   end

   assign grant = grant_q;
   assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_rd_arbiter
//
// Bench for axi_rd_arbiter with NM=2, TIMEOUT_CYC=16. Bursts are described by
// a table of {request mask, LEN, expected grant, master stall window}; each
// one is driven through a small slave model that returns data = captured
// address + beat. Expected beats are queued from the bench's own master
// fields when the address handshake happens and popped as the master sees
// data. Hand-written sequences cover VALID withdrawal, reset mid-burst and,
// when AXI_RD_ARB_TIMEOUT_EN is defined, the watchdog path.
// ---------------------------------------------------------------------------
module tb_axi_rd_arbiter;

   localparam int NM = 2;

   logic clk = 1'b0;
   logic rstn;

   logic [3:0]  m_id    [NM];
   logic [31:0] m_addr  [NM];
   logic [7:0]  m_len   [NM];
   logic [1:0]  m_burst [NM];

   logic [NM*4-1:0]  M_RD_ADDR_ID;
   logic [NM*32-1:0] M_RD_ADDR;
   logic [NM*8-1:0]  M_RD_ADDR_LEN;
   logic [NM*2-1:0]  M_RD_ADDR_BURST;
   logic [NM-1:0]    M_RD_ADDR_VALID, M_RD_ADDR_READY;
   logic [3:0]       M_RD_BACK_ID;
   logic [31:0]      M_RD_DATA;
   logic [1:0]       M_RD_DATA_RESP;
   logic             M_RD_DATA_LAST;
   logic [NM-1:0]    M_RD_DATA_VALID, M_RD_DATA_READY;
   logic [3:0]       S_RD_ADDR_ID;
   logic [31:0]      S_RD_ADDR;
   logic [7:0]       S_RD_ADDR_LEN;
   logic [1:0]       S_RD_ADDR_BURST;
   logic             S_RD_ADDR_VALID, S_RD_ADDR_READY;
   logic [3:0]       S_RD_BACK_ID;
   logic [31:0]      S_RD_DATA;
   logic [1:0]       S_RD_DATA_RESP;
   logic             S_RD_DATA_LAST, S_RD_DATA_VALID, S_RD_DATA_READY;
   logic [0:0]       grant;
   logic             busy;

   assign M_RD_ADDR_ID    = {m_id[1], m_id[0]};
   assign M_RD_ADDR       = {m_addr[1], m_addr[0]};
   assign M_RD_ADDR_LEN   = {m_len[1], m_len[0]};
   assign M_RD_ADDR_BURST = {m_burst[1], m_burst[0]};

   axi_rd_arbiter #(.NM(NM), .TIMEOUT_CYC(16)) dut (
      .clk             (clk),
      .rstn            (rstn),
      .M_RD_ADDR_ID    (M_RD_ADDR_ID),
      .M_RD_ADDR       (M_RD_ADDR),
      .M_RD_ADDR_LEN   (M_RD_ADDR_LEN),
      .M_RD_ADDR_BURST (M_RD_ADDR_BURST),
      .M_RD_ADDR_VALID (M_RD_ADDR_VALID),
      .M_RD_ADDR_READY (M_RD_ADDR_READY),
      .M_RD_BACK_ID    (M_RD_BACK_ID),
      .M_RD_DATA       (M_RD_DATA),
      .M_RD_DATA_RESP  (M_RD_DATA_RESP),
      .M_RD_DATA_LAST  (M_RD_DATA_LAST),
      .M_RD_DATA_VALID (M_RD_DATA_VALID),
      .M_RD_DATA_READY (M_RD_DATA_READY),
      .S_RD_ADDR_ID    (S_RD_ADDR_ID),
      .S_RD_ADDR       (S_RD_ADDR),
      .S_RD_ADDR_LEN   (S_RD_ADDR_LEN),
      .S_RD_ADDR_BURST (S_RD_ADDR_BURST),
      .S_RD_ADDR_VALID (S_RD_ADDR_VALID),
      .S_RD_ADDR_READY (S_RD_ADDR_READY),
      .S_RD_BACK_ID    (S_RD_BACK_ID),
      .S_RD_DATA       (S_RD_DATA),
      .S_RD_DATA_RESP  (S_RD_DATA_RESP),
      .S_RD_DATA_LAST  (S_RD_DATA_LAST),
      .S_RD_DATA_VALID (S_RD_DATA_VALID),
      .S_RD_DATA_READY (S_RD_DATA_READY),
      .grant           (grant),
      .busy            (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  id;
   } beat_t;

   typedef struct {
      logic [1:0] mask;
      logic [7:0] len;
      int         exp_g;
      int         stall_lo;
      int         stall_hi;
   } vec_t;

   beat_t exp_q[$];
   vec_t  vecs[6];
   int    n_vec = 0;
   int    n_err = 0;
   int    txn   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Advance to just after the next rising edge; inputs are driven here and
   // outputs sampled 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_burst(input vec_t v);
      logic [1:0]  oh;
      int          wait_cyc;
      int          beat;
      logic [31:0] cap_addr;
      logic [3:0]  cap_id;
      beat_t       e;
      oh = 2'b01 << v.exp_g;
      txn++;
      for (int i = 0; i < NM; i++) begin
         m_addr[i] = 32'h1000 * 32'(i + 1) + 32'(txn) * 32'h100;
         m_len[i]  = v.len;
      end
      M_RD_ADDR_VALID = v.mask;
      M_RD_DATA_READY = '1;
      S_RD_ADDR_READY = 1'b0;
      S_RD_DATA_VALID = 1'b0;
      S_RD_DATA_LAST  = 1'b0;
      #1;
      check("idle_s_addr_valid", 32'(S_RD_ADDR_VALID), 0);
      check("idle_s_addr_zero", S_RD_ADDR, 0);
      wait_cyc = 0;
      do begin
         step();
         wait_cyc++;
      end while (!S_RD_ADDR_VALID && wait_cyc < 4);
      check("addr_latency", 32'(wait_cyc), 1);
      if (!S_RD_ADDR_VALID) return;
      check("grant", 32'(grant), 32'(v.exp_g));
      check("busy_addr", 32'(busy), 1);
      check("s_addr", S_RD_ADDR, m_addr[v.exp_g]);
      check("s_addr_id", 32'(S_RD_ADDR_ID), 32'(m_id[v.exp_g]));
      check("s_addr_len", 32'(S_RD_ADDR_LEN), 32'(v.len));
      check("s_addr_burst", 32'(S_RD_ADDR_BURST), 32'(m_burst[v.exp_g]));
      S_RD_ADDR_READY = 1'b1;
      #1;
      check("m_addr_ready", 32'(M_RD_ADDR_READY), 32'(oh));
      cap_addr = S_RD_ADDR;
      cap_id   = S_RD_ADDR_ID;
      for (int b = 0; b <= int'(v.len); b++)
         exp_q.push_back('{data: m_addr[v.exp_g] + 32'(b), id: m_id[v.exp_g]});
      step();
      S_RD_ADDR_READY = 1'b0;
      beat = 0;
      for (int cyc = 0; cyc < 64 && beat <= int'(v.len); cyc++) begin
         S_RD_DATA_VALID = 1'b1;
         S_RD_DATA       = cap_addr + 32'(beat);
         S_RD_DATA_LAST  = (beat == int'(v.len));
         S_RD_BACK_ID    = cap_id;
         S_RD_DATA_RESP  = 2'b00;
         M_RD_DATA_READY = '1;
         if (cyc >= v.stall_lo && cyc <= v.stall_hi) M_RD_DATA_READY[v.exp_g] = 1'b0;
         #1;
         check("m_data_valid", 32'(M_RD_DATA_VALID), 32'(oh));
         check("s_data_ready", 32'(S_RD_DATA_READY), 32'(M_RD_DATA_READY[v.exp_g]));
         check("m_addr_ready_data", 32'(M_RD_ADDR_READY), 0);
         if (M_RD_DATA_VALID[v.exp_g] && M_RD_DATA_READY[v.exp_g]) begin
            if (exp_q.size() == 0) begin
               check("sb_underflow", 32'(exp_q.size()), 1);
            end
            else begin
               e = exp_q.pop_front();
               check("m_data", M_RD_DATA, e.data);
               check("m_back_id", 32'(M_RD_BACK_ID), 32'(e.id));
               check("m_last", 32'(M_RD_DATA_LAST), 32'(beat == int'(v.len)));
            end
         end
         else begin
            check("held_data", M_RD_DATA, cap_addr + 32'(beat));
         end
         if (S_RD_DATA_READY) beat++;
         step();
      end
      S_RD_DATA_VALID = 1'b0;
      S_RD_DATA_LAST  = 1'b0;
      #1;
      check("busy_after_last", 32'(busy), 0);
      check("valid_after_last", 32'(M_RD_DATA_VALID), 0);
      check("sb_drained", 32'(exp_q.size()), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "bench time limit");
   end

   initial begin
      // {mask, LEN, expected grant, stall window start, stall window end}
      vecs[0] = '{2'b11, 8'd0, 0, -1, -1};
      vecs[1] = '{2'b11, 8'd0, 1, -1, -1};
      vecs[2] = '{2'b11, 8'd0, 0, -1, -1};
      vecs[3] = '{2'b11, 8'd0, 1, -1, -1};
      vecs[4] = '{2'b01, 8'd3, 0, -1, -1};
      vecs[5] = '{2'b10, 8'd7, 1,  2,  3};

      rstn = 1'b0;
      for (int i = 0; i < NM; i++) begin
         m_id[i]    = 4'(5 + i);
         m_addr[i]  = '0;
         m_len[i]   = '0;
         m_burst[i] = 2'b01;
      end
      M_RD_ADDR_VALID = '0;
      M_RD_DATA_READY = '0;
      S_RD_ADDR_READY = 1'b0;
      S_RD_BACK_ID    = '0;
      S_RD_DATA       = '0;
      S_RD_DATA_RESP  = '0;
      S_RD_DATA_LAST  = 1'b0;
      S_RD_DATA_VALID = 1'b0;
      step();
      step();
      check("rst_busy", 32'(busy), 0);
      check("rst_grant", 32'(grant), 1);
      check("rst_s_addr_valid", 32'(S_RD_ADDR_VALID), 0);
      check("rst_m_addr_ready", 32'(M_RD_ADDR_READY), 0);
      check("rst_m_data_valid", 32'(M_RD_DATA_VALID), 0);
      check("rst_s_data_ready", 32'(S_RD_DATA_READY), 0);
      rstn = 1'b1;
      step();

      for (int i = 0; i < 6; i++) run_burst(vecs[i]);

      // VALID withdrawal in ADDR: master 0 drops before the slave is ready.
      M_RD_ADDR_VALID = 2'b01;
      S_RD_ADDR_READY = 1'b0;
      #1;
      step();
      check("wd_grant", 32'(grant), 0);
      check("wd_s_addr_valid", 32'(S_RD_ADDR_VALID), 1);
      check("wd_m_addr_ready", 32'(M_RD_ADDR_READY), 0);
      M_RD_ADDR_VALID = 2'b10;
      #1;
      check("wd_drop_s_valid", 32'(S_RD_ADDR_VALID), 0);
      step();
      check("wd_busy", 32'(busy), 0);
      check("wd_grant_kept", 32'(grant), 0);
      run_burst('{2'b10, 8'd0, 1, -1, -1});

      // Reset on beat 3 of an 8-beat burst from master 0.
      M_RD_ADDR_VALID = 2'b01;
      m_len[0] = 8'd7;
      #1;
      step();
      check("rb_grant", 32'(grant), 0);
      S_RD_ADDR_READY = 1'b1;
      step();
      S_RD_ADDR_READY = 1'b0;
      M_RD_ADDR_VALID = '0;
      M_RD_DATA_READY = '1;
      for (int b = 0; b < 3; b++) begin
         S_RD_DATA_VALID = 1'b1;
         S_RD_DATA       = 32'(b);
         S_RD_DATA_LAST  = 1'b0;
         step();
      end
      S_RD_DATA_VALID = 1'b1;
      S_RD_DATA       = 32'd3;
      #1;
      check("rb_pre_valid", 32'(M_RD_DATA_VALID), 32'(2'b01));
      rstn = 1'b0;
      #1;
      check("rb_m_data_valid", 32'(M_RD_DATA_VALID), 0);
      check("rb_s_data_ready", 32'(S_RD_DATA_READY), 0);
      check("rb_m_data", M_RD_DATA, 0);
      check("rb_s_addr_valid", 32'(S_RD_ADDR_VALID), 0);
      check("rb_m_addr_ready", 32'(M_RD_ADDR_READY), 0);
      check("rb_busy", 32'(busy), 0);
      check("rb_grant", 32'(grant), 1);
      S_RD_DATA_VALID = 1'b0;
      step();
      step();
      rstn = 1'b1;
      run_burst('{2'b11, 8'd0, 0, -1, -1});

`ifdef AXI_RD_ARB_TIMEOUT_EN
      // Slave accepts the address but never returns data.
      M_RD_ADDR_VALID = 2'b01;
      #1;
      step();
      check("to_grant", 32'(grant), 0);
      S_RD_ADDR_READY = 1'b1;
      step();
      S_RD_ADDR_READY = 1'b0;
      M_RD_ADDR_VALID = '0;
      M_RD_DATA_READY = '0;
      for (int i = 0; i < 16; i++) begin
         #1;
         check("to_wait_valid", 32'(M_RD_DATA_VALID), 0);
         step();
      end
      check("err_valid", 32'(M_RD_DATA_VALID), 32'(2'b01));
      check("err_resp", 32'(M_RD_DATA_RESP), 32'(2'b10));
      check("err_last", 32'(M_RD_DATA_LAST), 1);
      check("err_data", M_RD_DATA, 0);
      check("err_id", 32'(M_RD_BACK_ID), 32'(m_id[0]));
      step();
      check("err_hold", 32'(M_RD_DATA_VALID), 32'(2'b01));
      M_RD_DATA_READY = 2'b01;
      step();
      check("flush_valid", 32'(M_RD_DATA_VALID), 0);
      check("flush_s_ready", 32'(S_RD_DATA_READY), 1);
      check("flush_busy", 32'(busy), 1);
      S_RD_DATA_VALID = 1'b1;
      S_RD_DATA_LAST  = 1'b1;
      S_RD_DATA       = 32'hDEAD_BEEF;
      #1;
      check("flush_no_fwd", 32'(M_RD_DATA_VALID), 0);
      step();
      S_RD_DATA_VALID = 1'b0;
      S_RD_DATA_LAST  = 1'b0;
      #1;
      check("flush_done_busy", 32'(busy), 0);
`endif

      check("final_sb_empty", 32'(exp_q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
